// File: rtl/gm64_pkg.sv
// rtl/gm64_pkg.sv - shared types and constants for the GM64 reset sequencer
package gm64_pkg;

    typedef enum logic [1:0] {
        SEQ_HOLD     = 2'd0,
        SEQ_DELAY    = 2'd1,
        SEQ_WAIT_ACK = 2'd2,
        SEQ_DONE     = 2'd3
    } seq_state_t;

    localparam int STAGE_CPU = 0;
    localparam int STAGE_VIC = 1;
    localparam int STAGE_SID = 2;
    localparam int STAGE_CIA = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - asynchronous-assert, synchronous-deassert reset synchronizer
module reset_sync #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic sync_rst_n
);

    logic [SYNC_DEPTH-1:0] chain;

    // Shift ones in after release; any low on arst_n clears the whole chain at once.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign sync_rst_n = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of GM64 subsystem resets with ack/timeout handshake
module reset_sequencer
    import gm64_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 8,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  seq_error
);

    localparam int CNT_MAX = max3(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYCLES);
    // The acknowledging cycle already counts as the first delay cycle.
    localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'((STAGE_DELAY > 1) ? STAGE_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] ACK_LIM   = CNT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(STAGE_CPU);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic                  int_rst_n;

    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  release_stb;
    logic                  timeout_stb;

    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    reset_sync #(
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_reset_sync (
        .clk        (clk),
        .arst_n     (reset),
        .sync_rst_n (int_rst_n)
    );

    // State, shared counter, stage index and registered outputs.
    always_ff @(posedge clk or negedge int_rst_n) begin
        if (!int_rst_n) begin
            state_q <= SEQ_HOLD;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_FIRST;
            rst_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: one saturating counter serves hold, delay and ack timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        release_stb = 1'b0;
        timeout_stb = 1'b0;
        cnt_inc     = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

        if (soft_req) begin
            // The request cycle itself is the first hold cycle, so holding the
            // request keeps restarting the hold from its last high cycle.
            state_d = SEQ_HOLD;
            cnt_d   = CNT_ONE;
            idx_d   = IDX_FIRST;
        end else begin
            case (state_q)
                SEQ_HOLD: begin
                    if (cnt_q >= HOLD_LIM) begin
                        // Stage 0 has no inter-stage delay: release it straight away.
                        state_d     = SEQ_WAIT_ACK;
                        cnt_d       = CNT_ZERO;
                        idx_d       = IDX_FIRST;
                        release_stb = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                SEQ_DELAY: begin
                    if (cnt_q >= DELAY_LIM) begin
                        state_d     = SEQ_WAIT_ACK;
                        cnt_d       = CNT_ZERO;
                        release_stb = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                SEQ_WAIT_ACK: begin
                    if (stage_ack[idx_q] || (cnt_q >= ACK_LIM)) begin
                        timeout_stb = ~stage_ack[idx_q];
                        cnt_d       = CNT_ONE;
                        if (idx_q == IDX_LAST) begin
                            state_d = SEQ_DONE;
                        end else begin
                            state_d = SEQ_DELAY;
                            idx_d   = idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                SEQ_DONE: begin
                    state_d = SEQ_DONE;
                end
                default: begin
                    state_d = SEQ_HOLD;
                    cnt_d   = CNT_ZERO;
                    idx_d   = IDX_FIRST;
                end
            endcase
        end
    end

    // Output next values; released stages stay released until restart.
    always_comb begin
        rst_d  = rst_q;
        busy_d = busy_q;
        done_d = done_q;
        err_d  = err_q;

        if (soft_req) begin
            rst_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
        end else begin
            if (release_stb) begin
                rst_d[idx_d] = 1'b1;
            end
            if (timeout_stb) begin
                err_d = 1'b1;
            end
            if (state_d == SEQ_DONE) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign rst_out_n = rst_q;
    assign busy      = busy_q;
    assign seq_done  = done_q;
    assign seq_error = err_q;

endmodule
